sdram_rd_stream: RTL and testbench

//   Downstream stage of the SDRAM controller read path. Captures 16-bit words from the SDRAM DQ bus

---
 rtl/sdram_rd_stream.sv | 160 ++++++++++++++++
 tb/tb_sdram_rd_stream.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_rd_stream.sv
// sdram_rd_stream: buffers 16-bit SDRAM burst words in a show-ahead FIFO and
// streams them out as bytes (low byte first) to a 245-style USB FIFO port.
module sdram_rd_stream #(
    parameter int DEPTH      = 1024,
    parameter int ADDR_W     = 10,
    parameter int PAGE_WORDS = 512
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [15:0] sdram_q,
    input  logic        sdram_q_asserted,
    output logic        page_rdy,
    input  logic        usb_txe_n,
    output logic        usb_wr_n,
    output logic [7:0]  usb_d,
    output logic        overflow,
    output logic        burst_len_err
);

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] PAGE_CNT  = (ADDR_W + 1)'(PAGE_WORDS);
    localparam logic [ADDR_W:0] RUN_MAX   = '1;

    logic [15:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   run_cnt;
    logic [15:0]       head;
    logic [15:0]       word_reg;
    logic [15:0]       word_next;
    logic [7:0]        d_next;
    logic              wr_n_next;
    logic              full;
    logic              push;
    logic              pop;
    logic              accepted;
    state_t            state;
    state_t            state_next;

    // A full FIFO drops the incoming word even if a pop frees a slot this cycle.
    assign full     = (count == DEPTH_CNT);
    assign push     = sdram_q_asserted && !full;
    assign head     = mem[rd_ptr];
    assign accepted = !usb_wr_n && !usb_txe_n;
    assign page_rdy = ((DEPTH_CNT - count) >= PAGE_CNT);

    // Word storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= sdram_q;
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (sdram_q_asserted && full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Measure each q_asserted run and flag any run that is not exactly one page.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            run_cnt       <= '0;
            burst_len_err <= 1'b0;
        end else if (sdram_q_asserted) begin
            if (run_cnt != RUN_MAX) begin
                run_cnt <= run_cnt + 1'b1;
            end
        end else if (run_cnt != '0) begin
            if (run_cnt != PAGE_CNT) begin
                burst_len_err <= 1'b1;
            end
            run_cnt <= '0;
        end
    end

    // Output state register together with the registered USB strobe and data.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state    <= IDLE;
            usb_wr_n <= 1'b1;
            usb_d    <= 8'h00;
            word_reg <= 16'h0000;
        end else begin
            state    <= state_next;
            usb_wr_n <= wr_n_next;
            usb_d    <= d_next;
            word_reg <= word_next;
        end
    end

    // Byte sequencer: pop a word, present low byte, then high byte, chaining words back to back.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        wr_n_next  = usb_wr_n;
        d_next     = usb_d;
        word_next  = word_reg;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    word_next  = head;
                    d_next     = head[7:0];
                    wr_n_next  = 1'b0;
                    state_next = LO;
                end
            end
            LO: begin
                if (accepted) begin
                    d_next     = word_reg[15:8];
                    state_next = HI;
                end
            end
            HI: begin
                if (accepted) begin
                    if (count != '0) begin
                        pop        = 1'b1;
                        word_next  = head;
                        d_next     = head[7:0];
                        state_next = LO;
                    end else begin
                        wr_n_next  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sdram_rd_stream.sv
// tb_sdram_rd_stream: directed and randomized bench for sdram_rd_stream,
// checked every cycle against a queue-based model of the byte stream.
module tb_sdram_rd_stream;

    localparam int DEPTH = 1024;
    localparam int PAGE  = 512;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [15:0] sdram_q = 16'h0000;
    logic        sdram_q_asserted = 1'b0;
    logic        page_rdy;
    logic        usb_txe_n = 1'b1;
    logic        usb_wr_n;
    logic [7:0]  usb_d;
    logic        overflow;
    logic        burst_len_err;

    int total = 0;
    int passed = 0;
    bit check_en = 1'b0;

    // Model: words still in the buffer, plus what the USB port should be showing.
    logic [15:0] mq[$];
    int          m_bytes_left = 0;
    logic [7:0]  m_d = 8'h00;
    logic [7:0]  m_hi = 8'h00;
    logic        m_wr_n = 1'b1;
    logic        m_ovf = 1'b0;
    logic        m_err = 1'b0;
    int          m_run = 0;
    logic        m_prev_q = 1'b0;

    logic [7:0]  acc_q[$];
    logic        last_wr_n = 1'b1;
    logic [7:0]  last_d = 8'h00;

    sdram_rd_stream dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .sdram_q          (sdram_q),
        .sdram_q_asserted (sdram_q_asserted),
        .page_rdy         (page_rdy),
        .usb_txe_n        (usb_txe_n),
        .usb_wr_n         (usb_wr_n),
        .usb_d            (usb_d),
        .overflow         (overflow),
        .burst_len_err    (burst_len_err)
    );

    // 48 MHz-ish clock; exact period is irrelevant to the design.
    always #10 clk = ~clk;

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge from the rules of the byte stream.
    always @(posedge clk) begin
        logic        acc;
        logic        was_full;
        logic        has_word;
        logic        take;
        logic [15:0] w;
        if (!n_rst) begin
            mq.delete();
            m_bytes_left = 0;
            m_d = 8'h00;
            m_hi = 8'h00;
            m_wr_n = 1'b1;
            m_ovf = 1'b0;
            m_err = 1'b0;
            m_run = 0;
            m_prev_q = 1'b0;
        end else begin
            acc = !m_wr_n && !usb_txe_n;
            was_full = (mq.size() == DEPTH);
            has_word = (mq.size() > 0);
            take = 1'b0;
            if (m_bytes_left == 0) begin
                take = has_word;
            end else if (acc && m_bytes_left == 2) begin
                m_d = m_hi;
                m_bytes_left = 1;
            end else if (acc && m_bytes_left == 1) begin
                if (has_word) begin
                    take = 1'b1;
                end else begin
                    m_wr_n = 1'b1;
                    m_bytes_left = 0;
                end
            end
            if (take) begin
                w = mq.pop_front();
                m_d = w[7:0];
                m_hi = w[15:8];
                m_wr_n = 1'b0;
                m_bytes_left = 2;
            end
            if (sdram_q_asserted) begin
                if (was_full) m_ovf = 1'b1;
                else mq.push_back(sdram_q);
                m_run++;
            end else if (m_prev_q) begin
                if (m_run != PAGE) m_err = 1'b1;
                m_run = 0;
            end
            m_prev_q = sdram_q_asserted;
        end
    end

    // Compare every DUT output against the model shortly after each edge.
    always @(posedge clk) begin
        #1;
        last_wr_n = usb_wr_n;
        last_d = usb_d;
        if (check_en) begin
            check_output("usb_wr_n", 16'(usb_wr_n), 16'(m_wr_n));
            check_output("usb_d", 16'(usb_d), 16'(m_d));
            check_output("page_rdy", 16'(page_rdy), 16'((DEPTH - mq.size()) >= PAGE));
            check_output("overflow", 16'(overflow), 16'(m_ovf));
            check_output("burst_len_err", 16'(burst_len_err), 16'(m_err));
        end
    end

    // Record every byte the USB side takes, using outputs sampled after the previous edge.
    always @(posedge clk) begin
        if (n_rst && !last_wr_n && !usb_txe_n) begin
            acc_q.push_back(last_d);
        end
    end

    // Hard stop in case the sequence ever wedges.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        sdram_q_asserted = 1'b0;
        tick(2);
        n_rst = 1'b1;
        acc_q.delete();
    endtask

    task automatic apply_stimulus(input logic [15:0] base, input int len, input bit txe_rand);
        for (int i = 0; i < len; i++) begin
            sdram_q = base + 16'(i);
            sdram_q_asserted = 1'b1;
            if (txe_rand) usb_txe_n = ($urandom_range(0, 2) == 0);
            @(negedge clk);
        end
        sdram_q_asserted = 1'b0;
        sdram_q = 16'h0000;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        usb_txe_n = 1'b0;
        while (!(mq.size() == 0 && m_bytes_left == 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_output("drain_done", 16'(mq.size() == 0 && m_bytes_left == 0), 16'd1);
        tick(2);
    endtask

    initial begin
        logic [15:0] w;
        logic [7:0]  eb;
        int          k;

        // Reset values
        tick(2);
        check_en = 1'b1;
        check_output("rst_wr_n", 16'(usb_wr_n), 16'd1);
        check_output("rst_d", 16'(usb_d), 16'h00);
        check_output("rst_page_rdy", 16'(page_rdy), 16'd1);
        check_output("rst_overflow", 16'(overflow), 16'd0);
        check_output("rst_burst_err", 16'(burst_len_err), 16'd0);
        n_rst = 1'b1;

        // Full page with the USB side always ready
        do_reset();
        usb_txe_n = 1'b0;
        apply_stimulus(16'h0000, 512, 1'b0);
        wait_drain(2000);
        check_output("page_byte_count", 16'(acc_q.size()), 16'd1024);
        for (int i = 0; i < acc_q.size() && i < 1024; i++) begin
            w = 16'(i / 2);
            eb = (i % 2 == 0) ? w[7:0] : w[15:8];
            check_output("page_byte", 16'(acc_q[i]), 16'(eb));
        end
        check_output("page_burst_err", 16'(burst_len_err), 16'd0);

        // Stall with the low byte on the bus
        do_reset();
        usb_txe_n = 1'b1;
        apply_stimulus(16'hA55A, 1, 1'b0);
        tick(4);
        check_output("stall_d", 16'(usb_d), 16'h5A);
        check_output("stall_wr_n", 16'(usb_wr_n), 16'd0);
        wait_drain(20);
        check_output("stall_count", 16'(acc_q.size()), 16'd2);
        if (acc_q.size() == 2) begin
            check_output("stall_lo", 16'(acc_q[0]), 16'h5A);
            check_output("stall_hi", 16'(acc_q[1]), 16'hA5);
        end
        check_output("stall_idle", 16'(usb_wr_n), 16'd1);

        // Overflow: the first word sits in the output register, so 1024 more fit
        // in the buffer and the third burst contributes only its first word.
        do_reset();
        usb_txe_n = 1'b1;
        for (int b = 0; b < 3; b++) begin
            apply_stimulus(16'(b << 12), 512, 1'b0);
            tick(2);
        end
        check_output("ovf_flag", 16'(overflow), 16'd1);
        wait_drain(4000);
        check_output("ovf_byte_count", 16'(acc_q.size()), 16'd2050);
        for (int i = 0; i < acc_q.size() && i < 2050; i++) begin
            k = i / 2;
            w = (k < 1024) ? 16'(((k / 512) << 12) | (k % 512)) : 16'h2000;
            eb = (i % 2 == 0) ? w[7:0] : w[15:8];
            check_output("ovf_byte", 16'(acc_q[i]), 16'(eb));
        end

        // Short burst sets the sticky length error one cycle after the run ends
        do_reset();
        usb_txe_n = 1'b0;
        apply_stimulus(16'h1000, 511, 1'b0);
        check_output("short_before", 16'(burst_len_err), 16'd0);
        tick(1);
        check_output("short_after", 16'(burst_len_err), 16'd1);
        tick(3);
        apply_stimulus(16'h2000, 512, 1'b0);
        tick(3);
        check_output("short_sticky", 16'(burst_len_err), 16'd1);
        wait_drain(2000);

        // Reset while the high byte is on the bus with 100 words buffered
        do_reset();
        usb_txe_n = 1'b1;
        apply_stimulus(16'h3000, 101, 1'b0);
        tick(2);
        usb_txe_n = 1'b0;
        tick(1);
        check_output("mid_hi_d", 16'(usb_d), 16'h30);
        check_output("mid_buffered", 16'(mq.size()), 16'd100);
        n_rst = 1'b0;
        tick(1);
        check_output("mid_rst_wr_n", 16'(usb_wr_n), 16'd1);
        n_rst = 1'b1;
        acc_q.delete();
        tick(50);
        check_output("mid_no_strobe", 16'(acc_q.size()), 16'd0);
        check_output("mid_page_rdy", 16'(page_rdy), 16'd1);

        // Randomized bursts, gaps and USB back-pressure
        do_reset();
        for (int r = 0; r < 8; r++) begin
            k = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 600) : PAGE;
            apply_stimulus(16'($urandom), k, 1'b1);
            for (int g = 0; g < $urandom_range(1, 20); g++) begin
                usb_txe_n = ($urandom_range(0, 2) == 0);
                tick(1);
            end
        end
        wait_drain(6000);

        check_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
